// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and sequencing stage for the toy accumulator CPU.
// Holds the PC, fetches a word over a req/ack handshake, latches it into the
// instruction register, and applies the controller's next-PC select after
// execution. The undefined opcode 4'b0111 traps into an absorbing HALT state.
// Optional: define FETCH_RETIRE_CNT_EN to add the saturating retire_cnt output.
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [PC_W+3:0]   imem_rdata,
   output logic [3:0]        opcode,
   output logic [PC_W-1:0]   operand,
   output logic              instr_valid,
   input  logic [1:0]        src_pc,
   input  logic              exec_stall,
   output logic [PC_W-1:0]   pc,
   output logic              halted
`ifdef FETCH_RETIRE_CNT_EN
   ,
   output logic [15:0]       retire_cnt
`endif
);

   localparam int         INSTR_W = 4 + PC_W;
   localparam logic [3:0] OP_TRAP = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [INSTR_W-1:0]   r_ir;
   logic [PC_W-1:0]      r_pc;
   logic [PC_W-1:0]      w_pc_next;
   logic [PC_W-1:0]      w_pc_inc;
   logic [3:0]           w_op;
   logic [PC_W-1:0]      w_opnd;
   logic                 w_ack_take;
   logic                 w_exec_done;
   logic                 w_trap;
   logic                 w_retire;

   // IR field decode; opcode/operand come straight from IR so they hold for all of EXEC
   assign w_op   = r_ir[INSTR_W-1:INSTR_W-4];
   assign w_opnd = r_ir[PC_W-1:0];

   // ack only counts while a fetch is outstanding; acks in any other state are dropped
   assign w_ack_take  = (r_state == S_FETCH) && imem_ack;
   assign w_exec_done = (r_state == S_EXEC) && !exec_stall;
   assign w_trap      = w_exec_done && (w_op == OP_TRAP);
   assign w_retire    = w_exec_done && (w_op != OP_TRAP);

   // sequential successor wraps modulo 2^PC_W with no carry-out
   assign w_pc_inc = PC_W'(r_pc + 1'b1);

   // next-PC select; reserved code and any unknown fall back to sequential
   always_comb begin
      w_pc_next = w_pc_inc;
      case (src_pc)
         2'b01:   w_pc_next = w_opnd;
         2'b10:   w_pc_next = w_opnd;
         default: w_pc_next = w_pc_inc;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  w_next_state = S_FETCH;
         S_FETCH: if (w_ack_take) w_next_state = S_EXEC;
         S_EXEC: begin
            if (w_trap)        w_next_state = S_HALT;
            else if (w_retire) w_next_state = S_FETCH;
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs decoded purely from state so reset clears them without a clock
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      case (r_state)
         S_FETCH: imem_req    = 1'b1;
         S_EXEC:  instr_valid = 1'b1;
         S_HALT:  halted      = 1'b1;
         default: ;
      endcase
   end

   // instruction register: loads only on an accepted fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_ir <= '0;
      else if (w_ack_take) r_ir <= imem_rdata;
   end

   // PC: advances only when an instruction retires; stall and trap both hold it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_pc <= RESET_PC;
      else if (w_retire) r_pc <= w_pc_next;
   end

`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0] r_retire_cnt;

   // retired-instruction counter, saturating; the trap exit is not a retire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_retire_cnt <= '0;
      else if (w_retire && (r_retire_cnt != 16'hFFFF))
         r_retire_cnt <= r_retire_cnt + 16'd1;
   end

   assign retire_cnt = r_retire_cnt;
`endif

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign opcode    = w_op;
   assign operand   = w_opnd;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (PC_W=8, RESET_PC=0).
// Inputs change at negedge, outputs are observed at negedge or just after
// an asynchronous reset edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [11:0] imem_rdata = '0;
   logic [3:0]  opcode;
   logic [7:0]  operand;
   logic        instr_valid;
   logic [1:0]  src_pc = 2'b00;
   logic        exec_stall = 1'b0;
   logic [7:0]  pc;
   logic        halted;
`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   int checks = 0;
   int failures = 0;

   fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .opcode      (opcode),
      .operand     (operand),
      .instr_valid (instr_valid),
      .src_pc      (src_pc),
      .exec_stall  (exec_stall),
      .pc          (pc),
      .halted      (halted)
`ifdef FETCH_RETIRE_CNT_EN
      ,
      .retire_cnt  (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Called at a negedge in FETCH; holds ack off for dly cycles, watching req/addr,
   // then pulses ack with word w. Returns at the negedge after the accepting edge.
   task automatic give_ack(input int dly, input logic [11:0] w, output bit stable);
      logic [7:0] a0;
      a0 = imem_addr;
      stable = (imem_req === 1'b1);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         if (imem_req !== 1'b1 || imem_addr !== a0) stable = 1'b0;
      end
      imem_ack = 1'b1;
      imem_rdata = w;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = '0;
   endtask

   // Called at a negedge in EXEC; releases the instruction with next-PC select s.
   task automatic retire(input logic [1:0] s);
      exec_stall = 1'b0;
      src_pc = s;
      @(negedge clk);
      src_pc = 2'b00;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b exp 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b exp 0", halted); end
      checks++; if (pc !== 8'h00 || imem_addr !== 8'h00) begin failures++; $display("FAIL rst_pc: got %h/%h exp 00", pc, imem_addr); end
      checks++; if (opcode !== 4'h0 || operand !== 8'h00) begin failures++; $display("FAIL rst_ir: got %h_%h exp 0_00", opcode, operand); end
`ifdef FETCH_RETIRE_CNT_EN
      checks++; if (retire_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt: got %0d exp 0", retire_cnt); end
`endif
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b exp 0", imem_req); end
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL first_fetch: got req=%b addr=%h exp 1/00", imem_req, imem_addr); end
   endtask

   task automatic test_sequential;
      bit st;
      give_ack(0, 12'h105, st);
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL seq_exec0: got v=%b r=%b exp 1/0", instr_valid, imem_req); end
      checks++; if (opcode !== 4'h1 || operand !== 8'h05) begin failures++; $display("FAIL seq_ir0: got %h_%h exp 1_05", opcode, operand); end
      retire(2'b00);
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin failures++; $display("FAIL seq_fetch1: got v=%b r=%b a=%h exp 0/1/01", instr_valid, imem_req, imem_addr); end
      give_ack(0, 12'h206, st);
      checks++; if (opcode !== 4'h2 || operand !== 8'h06 || instr_valid !== 1'b1) begin failures++; $display("FAIL seq_ir1: got %h_%h v=%b exp 2_06 v=1", opcode, operand, instr_valid); end
      retire(2'b00);
      checks++; if (imem_addr !== 8'h02 || instr_valid !== 1'b0) begin failures++; $display("FAIL seq_fetch2: got %h v=%b exp 02 v=0", imem_addr, instr_valid); end
   endtask

   task automatic test_jump;
      bit st;
      give_ack(0, 12'h040, st); retire(2'b01);
      checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL jump01: got %h exp 40", imem_addr); end
      give_ack(0, 12'hA10, st); retire(2'b00);
      checks++; if (imem_addr !== 8'h41) begin failures++; $display("FAIL seq00: got %h exp 41", imem_addr); end
      give_ack(0, 12'hA10, st); retire(2'b10);
      checks++; if (imem_addr !== 8'h10) begin failures++; $display("FAIL branch10: got %h exp 10", imem_addr); end
      give_ack(0, 12'hA20, st); retire(2'b11);
      checks++; if (imem_addr !== 8'h11) begin failures++; $display("FAIL rsvd11: got %h exp 11", imem_addr); end
   endtask

   task automatic test_stall;
      bit st;
      int vcnt;
      give_ack(3, 12'h305, st);
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL slow_req_stable: got %b exp 1", st); end
      vcnt = 0;
      if (instr_valid === 1'b1) vcnt++;
      // stray ack while stalled in EXEC must not reload IR
      exec_stall = 1'b1; imem_ack = 1'b1; imem_rdata = 12'h7FF;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = '0;
      if (instr_valid === 1'b1) vcnt++;
      checks++; if (opcode !== 4'h3 || operand !== 8'h05) begin failures++; $display("FAIL stall_ir: got %h_%h exp 3_05", opcode, operand); end
      checks++; if (pc !== 8'h11) begin failures++; $display("FAIL stall_pc1: got %h exp 11", pc); end
      @(negedge clk);
      if (instr_valid === 1'b1) vcnt++;
      checks++; if (pc !== 8'h11) begin failures++; $display("FAIL stall_pc2: got %h exp 11", pc); end
      retire(2'b00);
      checks++; if (vcnt !== 3 || instr_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_cycles: got %0d (now %b) exp 3 (now 0)", vcnt, instr_valid); end
      checks++; if (imem_addr !== 8'h12) begin failures++; $display("FAIL stall_next: got %h exp 12", imem_addr); end
   endtask

   task automatic test_wrap;
      bit st;
      give_ack(0, 12'h0FF, st); retire(2'b01);
      checks++; if (imem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_jump: got %h exp ff", imem_addr); end
      give_ack(0, 12'h1AA, st); retire(2'b00);
      checks++; if (imem_addr !== 8'h00 || pc !== 8'h00) begin failures++; $display("FAIL wrap: got %h exp 00", imem_addr); end
   endtask

   task automatic test_trap;
      bit st;
      bit bad;
      give_ack(0, 12'h733, st);
      checks++; if (opcode !== 4'h7 || instr_valid !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL trap_exec: got op=%h v=%b h=%b exp 7/1/0", opcode, instr_valid, halted); end
      retire(2'b01);
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL trap_halt: got h=%b v=%b r=%b exp 1/0/0", halted, instr_valid, imem_req); end
      checks++; if (pc !== 8'h00) begin failures++; $display("FAIL trap_pc: got %h exp 00", pc); end
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         imem_ack = (i % 3 == 0); imem_rdata = 12'h105;
         @(negedge clk);
         if (imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) bad = 1'b1;
      end
      imem_ack = 1'b0; imem_rdata = '0;
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL halt_absorb: got bad=%b exp 0", bad); end
      checks++; if (opcode !== 4'h7 || operand !== 8'h33) begin failures++; $display("FAIL halt_ir: got %h_%h exp 7_33", opcode, operand); end
   endtask

   task automatic test_async_reset;
      bit st;
      // reset out of HALT, checked before any clock edge
      @(negedge clk); #2 rst_n = 1'b0; #1;
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_from_halt: got %b exp 0", halted); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      give_ack(0, 12'h105, st); retire(2'b00);
      // reset mid-FETCH at pc=01
      #2 rst_n = 1'b0; #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h00) begin failures++; $display("FAIL rst_mid_fetch: got r=%b a=%h exp 0/00", imem_req, imem_addr); end
      @(posedge clk); #1 rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 12'h2AB;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL post_rst_idle: got %b exp 0", imem_req); end
      @(posedge clk); #1 imem_ack = 1'b0; imem_rdata = '0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0 || opcode !== 4'h0) begin failures++; $display("FAIL late_ack_ignored: got r=%b a=%h v=%b op=%h exp 1/00/0/0", imem_req, imem_addr, instr_valid, opcode); end
      // reset mid-EXEC while stalled at pc=01
      give_ack(0, 12'h105, st); retire(2'b00);
      give_ack(0, 12'h205, st);
      exec_stall = 1'b1;
      @(negedge clk); #2 rst_n = 1'b0; #1;
      checks++; if (instr_valid !== 1'b0 || pc !== 8'h00) begin failures++; $display("FAIL rst_mid_exec: got v=%b pc=%h exp 0/00", instr_valid, pc); end
      exec_stall = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
`ifdef FETCH_RETIRE_CNT_EN
      checks++; if (retire_cnt !== 16'd0) begin failures++; $display("FAIL cnt_after_rst: got %0d exp 0", retire_cnt); end
`endif
      for (int i = 0; i < 3; i++) begin
         give_ack(0, 12'h1C0, st); retire(2'b00);
      end
      checks++; if (imem_addr !== 8'h03) begin failures++; $display("FAIL three_retire_addr: got %h exp 03", imem_addr); end
`ifdef FETCH_RETIRE_CNT_EN
      checks++; if (retire_cnt !== 16'd3) begin failures++; $display("FAIL cnt_three: got %0d exp 3", retire_cnt); end
`endif
      give_ack(0, 12'h700, st); retire(2'b00);
      checks++; if (halted !== 1'b1 || pc !== 8'h03) begin failures++; $display("FAIL final_trap: got h=%b pc=%h exp 1/03", halted, pc); end
`ifdef FETCH_RETIRE_CNT_EN
      checks++; if (retire_cnt !== 16'd3) begin failures++; $display("FAIL cnt_trap_nocount: got %0d exp 3", retire_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jump();
      test_stall();
      test_wrap();
      test_trap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "timeout");
   end

endmodule
